// File: rtl/controle_contagem.sv
// Control FSM for the counter/comparator experiment: clears the counter, steps it at a
// DIVISOR-cycle rate and stops on a match or a wrap. Macro CONTROLE_REPETE_EN: restart on wrap.
module controle_contagem #(
    parameter int DIVISOR = 4
) (
    input  logic       clock,
    input  logic       clr,
    input  logic       iniciar,
    input  logic       igual,
    input  logic       fim,
    output logic       zera,
    output logic       conta,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic [3:0] db_estado
);

    localparam int DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [DW-1:0] DIV_FIM = DW'(DIVISOR - 1);

    typedef enum logic [3:0] {
        INICIAL = 4'b0000,
        PREPARA = 4'b0001,
        ESPERA  = 4'b0010,
        CONTA   = 4'b0011,
        COMPARA = 4'b0100,
        ACERTO  = 4'b1010,
        ERRO    = 4'b1110
    } estado_t;

    estado_t       estado;
    estado_t       estado_prox;
    logic [DW-1:0] divisor;

    // NOTE: default assignment first so every path assigns estado_prox and no latch is inferred.
    always_comb begin
        estado_prox = estado;
        case (estado)
            INICIAL: if (iniciar) estado_prox = PREPARA;
            PREPARA: estado_prox = COMPARA;
            COMPARA: begin
                if (igual) begin
                    estado_prox = ACERTO;
                end else if (fim) begin
`ifdef CONTROLE_REPETE_EN
                    estado_prox = PREPARA;
`else
                    estado_prox = ERRO;
`endif
                end else begin
                    estado_prox = ESPERA;
                end
            end
            ESPERA:  if (divisor == DIV_FIM) estado_prox = CONTA;
            CONTA:   estado_prox = COMPARA;
            ACERTO,
            ERRO:    if (iniciar) estado_prox = PREPARA;
            default: estado_prox = INICIAL;
        endcase
    end

    // Outputs are registered from the next state, so each one is a pure function of the
    // state register and changes on the same edge as the state itself.
    // NOTE: non-blocking assignments for all registers so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            estado  <= INICIAL;
            divisor <= '0;
            zera    <= 1'b0;
            conta   <= 1'b0;
            pronto  <= 1'b0;
            acertou <= 1'b0;
            errou   <= 1'b0;
        end else begin
            estado  <= estado_prox;
            divisor <= (estado == ESPERA && estado_prox == ESPERA) ? divisor + 1'b1 : '0;
            zera    <= (estado_prox == PREPARA);
            conta   <= (estado_prox == CONTA);
            pronto  <= (estado_prox == ACERTO) || (estado_prox == ERRO);
            acertou <= (estado_prox == ACERTO);
`ifdef CONTROLE_REPETE_EN
            errou   <= 1'b0;
`else
            errou   <= (estado_prox == ERRO);
`endif
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_controle_contagem.sv
// Scoreboard bench for controle_contagem: two instances (DIVISOR=4 and DIVISOR=1), each
// beside a behavioural counter/comparator; completion events are checked against a queue.
module tb_controle_contagem;

    logic clock = 1'b0;
    logic clr;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // instance 0: DIVISOR=4, instance 1: DIVISOR=1
    logic       iniciar4, iniciar1;
    logic [3:0] chaves4, chaves1;
    logic       zera4, conta4, pronto4, acertou4, errou4;
    logic       zera1, conta1, pronto1, acertou1, errou1;
    logic [3:0] db4, db1;
    logic [3:0] cnt4 = 4'd7, cnt1 = 4'd7;
    logic       igual4, fim4, igual1, fim1;

    always @(posedge clock) if (zera4) cnt4 <= 4'd0; else if (conta4) cnt4 <= cnt4 + 4'd1;
    always @(posedge clock) if (zera1) cnt1 <= 4'd0; else if (conta1) cnt1 <= cnt1 + 4'd1;
    assign igual4 = (cnt4 == chaves4);
    assign fim4   = (cnt4 == 4'd15);
    assign igual1 = (cnt1 == chaves1);
    assign fim1   = (cnt1 == 4'd15);

    controle_contagem #(.DIVISOR(4)) u_dut4 (
        .clock(clock), .clr(clr), .iniciar(iniciar4), .igual(igual4), .fim(fim4),
        .zera(zera4), .conta(conta4), .pronto(pronto4), .acertou(acertou4),
        .errou(errou4), .db_estado(db4)
    );

    controle_contagem #(.DIVISOR(1)) u_dut1 (
        .clock(clock), .clr(clr), .iniciar(iniciar1), .igual(igual1), .fim(fim1),
        .zera(zera1), .conta(conta1), .pronto(pronto1), .acertou(acertou1),
        .errou(errou1), .db_estado(db1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    typedef struct {
        int         inst;
        int         edge_n;
        logic [3:0] db;
        logic       acc;
        logic       err;
        int         pulses;
        logic [3:0] cnt;
        logic [1:0] flags;   // {fim, igual} seen in the last COMPARA
    } exp_t;

    exp_t sb_q[$];

    function automatic exp_t mk_exp(int inst, int edge_n, logic [3:0] db, logic acc, logic err,
                                    int pulses, logic [3:0] cnt, logic [1:0] flags);
        exp_t e;
        e.inst = inst; e.edge_n = edge_n; e.db = db; e.acc = acc; e.err = err;
        e.pulses = pulses; e.cnt = cnt; e.flags = flags;
        return e;
    endfunction

    function automatic int div_of(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // per-instance views for the monitor
    logic       zera_v [2], conta_v [2], pronto_v [2], acertou_v [2], errou_v [2];
    logic       fim_v [2], igual_v [2];
    logic [3:0] db_v [2], cnt_v [2];
    assign zera_v[0] = zera4;   assign zera_v[1] = zera1;
    assign conta_v[0] = conta4; assign conta_v[1] = conta1;
    assign pronto_v[0] = pronto4; assign pronto_v[1] = pronto1;
    assign acertou_v[0] = acertou4; assign acertou_v[1] = acertou1;
    assign errou_v[0] = errou4; assign errou_v[1] = errou1;
    assign fim_v[0] = fim4;     assign fim_v[1] = fim1;
    assign igual_v[0] = igual4; assign igual_v[1] = igual1;
    assign db_v[0] = db4;       assign db_v[1] = db1;
    assign cnt_v[0] = cnt4;     assign cnt_v[1] = cnt1;

    int         pulses [2]      = '{0, 0};
    int         last_pulse [2]  = '{0, 0};
    logic [1:0] last_flags [2]  = '{2'b00, 2'b00};
    logic       prev_pronto [2] = '{1'b0, 1'b0};

    always @(negedge clock) begin : monitor
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (zera_v[i]) begin
                check("zera_conta_excl", conta_v[i], 0);
                pulses[i]     <= 0;
                last_pulse[i] <= cyc;
            end
            if (conta_v[i]) begin
                check("conta_spacing", cyc - last_pulse[i], div_of(i) + 2);
                pulses[i]     <= pulses[i] + 1;
                last_pulse[i] <= cyc;
            end
            if (db_v[i] == 4'b0100) last_flags[i] <= {fim_v[i], igual_v[i]};
            if (pronto_v[i] && !prev_pronto[i]) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("done_inst", i, e.inst);
                    check("done_edge", cyc, e.edge_n);
                    check("done_db_estado", db_v[i], e.db);
                    check("done_acertou", acertou_v[i], e.acc);
                    check("done_errou", errou_v[i], e.err);
                    check("done_conta_pulses", pulses[i], e.pulses);
                    check("done_count", cnt_v[i], e.cnt);
                    check("done_flags", last_flags[i], e.flags);
                end
            end
            prev_pronto[i] <= pronto_v[i];
        end
    end

    task automatic wait_done(input int budget);
        int k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(negedge clock);
            k++;
        end
        if (sb_q.size() != 0) begin
            check("done_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        iniciar4 = 1'b0; iniciar1 = 1'b0;
        chaves4  = 4'd0; chaves1  = 4'd0;
        clr = 1'b1;
        #1 clr = 1'b0;

        @(negedge clock);
        check("reset_outs_d4", {zera4, conta4, pronto4, acertou4, errou4, db4}, 0);
        check("reset_outs_d1", {zera1, conta1, pronto1, acertou1, errou1, db1}, 0);
        clr = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_after_reset", db4, 0);

        // abort a run in the middle of ESPERA
        chaves4 = 4'd5; iniciar4 = 1'b1;
        @(negedge clock);
        iniciar4 = 1'b0;
        check("zera_in_prepara", zera4, 1);
        repeat (2) @(negedge clock);
        check("db_espera", db4, 4'b0010);
        #1 clr = 1'b0;
        #1 check("reset_async_outs", {zera4, conta4, pronto4, acertou4, errou4, db4}, 0);
        @(negedge clock);
        clr = 1'b1;
        repeat (3) @(negedge clock);
        check("stays_inicial", db4, 0);

        // DIVISOR=4, chaves=5: match at count 5, ACERTO at E32
        sb_q.push_back(mk_exp(0, cyc + 1 + 32, 4'b1010, 1'b1, 1'b0, 5, 4'd5, 2'b01));
        iniciar4 = 1'b1;
        @(negedge clock);
        iniciar4 = 1'b0;
        check("zera_e0_e1", zera4, 1);
        @(negedge clock);
        check("zera_single_cycle", zera4, 0);
        wait_done(200);

        // iniciar held in ACERTO restarts; chaves=0 matches at E2 with no conta
        chaves4 = 4'd0;
        sb_q.push_back(mk_exp(0, cyc + 1 + 2, 4'b1010, 1'b1, 1'b0, 0, 4'd0, 2'b01));
        iniciar4 = 1'b1;
        @(negedge clock);
        iniciar4 = 1'b0;
        check("restart_prepara", db4, 4'b0001);
        check("restart_pronto_low", pronto4, 0);
        wait_done(50);

        // DIVISOR=1, chaves=15: igual and fim both set, ACERTO at E47
        chaves1 = 4'd15;
        sb_q.push_back(mk_exp(1, cyc + 1 + 47, 4'b1010, 1'b1, 1'b0, 15, 4'd15, 2'b11));
        iniciar1 = 1'b1;
        @(negedge clock);
        iniciar1 = 1'b0;
        wait_done(200);

        // DIVISOR=1, chaves 9 -> 3 after count 6: counter reaches 15 without a match
        chaves1 = 4'd9;
`ifdef CONTROLE_REPETE_EN
        sb_q.push_back(mk_exp(1, cyc + 1 + 47 + 11, 4'b1010, 1'b1, 1'b0, 3, 4'd3, 2'b01));
`else
        sb_q.push_back(mk_exp(1, cyc + 1 + 47, 4'b1110, 1'b0, 1'b1, 15, 4'd15, 2'b10));
`endif
        iniciar1 = 1'b1;
        @(negedge clock);
        iniciar1 = 1'b0;
        for (int k = 0; k < 100 && cnt1 != 4'd6; k++) @(negedge clock);
        check("reach_count_six", cnt1, 6);
        chaves1 = 4'd3;
        wait_done(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
